rc4_key_search_ctrl: RTL and testbench

//  Parametrised brute-force key-search sequencer for the RC4 cracking datapath. Walks a key

---
 rtl/rc4_key_search_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: strided brute-force key-search sequencer driving init/shuffle/decrypt/check
// sub-blocks with start/finish handshakes, watchdog, sibling-stop and keys-tried count. Rev 1.0
`default_nettype none

module rc4_key_search_ctrl #(
  parameter int KEY_WIDTH     = 24,
  parameter int KEY_BASE      = 0,
  parameter int KEY_STRIDE    = 1,
  parameter int KEY_MAX       = 2**22-1,
  parameter int PHASE_TIMEOUT = 0,
  parameter int TO_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 stop_in,
  output logic                 init_start,
  input  logic                 init_finish,
  output logic                 shuffle_start,
  input  logic                 shuffle_finish,
  output logic                 decrypt_start,
  input  logic                 decrypt_finish,
  output logic                 check_start,
  input  logic                 check_finish,
  input  logic                 check_valid,
  output logic                 core_reset,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic [KEY_WIDTH:0]   keys_tried,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 error
);

  localparam logic [KEY_WIDTH-1:0] c_KEY_BASE = KEY_WIDTH'(KEY_BASE);
  localparam logic [KEY_WIDTH:0]   c_KEY_MAX  = (KEY_WIDTH+1)'(KEY_MAX);
  localparam logic [KEY_WIDTH:0]   c_STRIDE   = (KEY_WIDTH+1)'(KEY_STRIDE);
  localparam logic [TO_WIDTH-1:0]  c_TO_LAST  = TO_WIDTH'(PHASE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_INIT    = 3'd2,
    S_SHUFFLE = 3'd3,
    S_DECRYPT = 3'd4,
    S_CHECK   = 3'd5,
    S_NEXT    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t               r_state, w_state_n;
  logic [KEY_WIDTH-1:0] r_key, w_key_n;
  logic [KEY_WIDTH:0]   r_tried, w_tried_n, w_nxt;
  logic [TO_WIDTH-1:0]  r_wd, w_wd_n;
  logic                 r_found, w_found_n, r_error, w_error_n, r_stop, w_stop_n;
  logic                 r_busy, r_done, r_core_reset, w_core_reset_n;
  logic [3:0]           r_start;
  logic                 w_phase, w_expire, w_continue;

  assign w_nxt    = {1'b0, r_key} + c_STRIDE;
  assign w_phase  = (r_state == S_INIT) || (r_state == S_SHUFFLE) ||
                    (r_state == S_DECRYPT) || (r_state == S_CHECK);
  assign w_expire = (PHASE_TIMEOUT > 0) && (r_wd == c_TO_LAST);

  always_comb begin
    w_state_n = r_state;
    w_key_n   = r_key;
    w_tried_n = r_tried;
    w_found_n = r_found;
    w_error_n = r_error;
    w_stop_n  = r_busy ? (r_stop | stop_in) : r_stop;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (go) begin
          w_state_n = S_LOAD;
          w_key_n   = c_KEY_BASE;
          w_tried_n = '0;
          w_found_n = 1'b0;
          w_error_n = 1'b0;
          w_stop_n  = 1'b0;
        end
      end
      S_LOAD:    w_state_n = S_INIT;
      S_INIT:    if (init_finish)    w_state_n = S_SHUFFLE;
      S_SHUFFLE: if (shuffle_finish) w_state_n = S_DECRYPT;
      S_DECRYPT: if (decrypt_finish) w_state_n = S_CHECK;
      S_CHECK: begin
        if (check_finish) begin
          w_tried_n = r_tried + 1'b1;
          if (check_valid) begin
            w_state_n = S_DONE;
            w_found_n = 1'b1;
          end else begin
            w_state_n = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (r_stop || (w_nxt > c_KEY_MAX)) begin
          w_state_n = S_DONE;
          w_found_n = 1'b0;
        end else begin
          w_key_n   = w_nxt[KEY_WIDTH-1:0];
          w_state_n = S_INIT;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // A finish arriving on the expiry cycle has already moved the state on, so it wins.
    if (w_phase && (w_state_n == r_state) && w_expire) begin
      w_state_n = S_DONE;
      w_error_n = 1'b1;
      w_found_n = 1'b0;
    end

    w_wd_n = (w_phase && (w_state_n == r_state)) ? r_wd + 1'b1 : '0;

    // The NEXT decision is made from the same stop/limit values one cycle early so the
    // sub-block reset pulse lands in the NEXT cycle itself.
    w_continue      = !w_stop_n && (w_nxt <= c_KEY_MAX);
    w_core_reset_n  = (w_state_n == S_LOAD) || ((w_state_n == S_NEXT) && w_continue);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_key        <= c_KEY_BASE;
      r_tried      <= '0;
      r_wd         <= '0;
      r_found      <= 1'b0;
      r_error      <= 1'b0;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_reset <= 1'b0;
      r_start      <= '0;
    end else begin
      r_state      <= w_state_n;
      r_key        <= w_key_n;
      r_tried      <= w_tried_n;
      r_wd         <= w_wd_n;
      r_found      <= w_found_n;
      r_error      <= w_error_n;
      r_stop       <= w_stop_n;
      r_busy       <= (w_state_n != S_IDLE) && (w_state_n != S_DONE);
      r_done       <= (w_state_n == S_DONE);
      r_core_reset <= w_core_reset_n;
      r_start      <= {w_state_n == S_CHECK, w_state_n == S_DECRYPT,
                       w_state_n == S_SHUFFLE, w_state_n == S_INIT};
    end
  end

  assign init_start    = r_start[0];
  assign shuffle_start = r_start[1];
  assign decrypt_start = r_start[2];
  assign check_start   = r_start[3];
  assign core_reset    = r_core_reset;
  assign secret_key    = r_key;
  assign keys_tried    = r_tried;
  assign busy          = r_busy;
  assign done          = r_done;
  assign found         = r_found;
  assign error         = r_error;

endmodule

`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
// tb_rc4_key_search_ctrl: directed bench with stub sub-blocks that finish 3 cycles after start.
// Instance A: BASE=0 STRIDE=1 MAX=7 TIMEOUT=10; instance B: BASE=2 STRIDE=4 MAX=13.
`default_nettype none
`timescale 1ns/1ps

module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A signals
  logic       a_go = 1'b0, a_stop = 1'b0;
  logic [3:0] a_st, a_fn;
  logic [3:0] a_en = 4'hF;
  logic       a_cr, a_busy, a_done, a_found, a_err, a_valid;
  logic [7:0] a_key;
  logic [8:0] a_tried;
  logic       a_valid_en = 1'b0;
  logic [7:0] a_target = 8'd0;
  int         a_cnt[4];
  int         a_crc = 0;

  // Instance B signals
  logic       b_go = 1'b0;
  logic [3:0] b_st, b_fn;
  logic       b_cr, b_busy, b_done, b_found, b_err;
  logic [7:0] b_key;
  logic [8:0] b_tried;
  int         b_cnt[4];
  logic [7:0] b_seen[4];
  int         b_nseen;

  assign a_valid = a_valid_en && (a_key == a_target);

  rc4_key_search_ctrl #(
    .KEY_WIDTH(8), .KEY_BASE(0), .KEY_STRIDE(1), .KEY_MAX(7),
    .PHASE_TIMEOUT(10), .TO_WIDTH(16)
  ) u_dut_a (
    .clk(clk), .reset(rst), .go(a_go), .stop_in(a_stop),
    .init_start(a_st[0]), .init_finish(a_fn[0]),
    .shuffle_start(a_st[1]), .shuffle_finish(a_fn[1]),
    .decrypt_start(a_st[2]), .decrypt_finish(a_fn[2]),
    .check_start(a_st[3]), .check_finish(a_fn[3]), .check_valid(a_valid),
    .core_reset(a_cr), .secret_key(a_key), .keys_tried(a_tried),
    .busy(a_busy), .done(a_done), .found(a_found), .error(a_err)
  );

  rc4_key_search_ctrl #(
    .KEY_WIDTH(8), .KEY_BASE(2), .KEY_STRIDE(4), .KEY_MAX(13),
    .PHASE_TIMEOUT(0), .TO_WIDTH(16)
  ) u_dut_b (
    .clk(clk), .reset(rst), .go(b_go), .stop_in(1'b0),
    .init_start(b_st[0]), .init_finish(b_fn[0]),
    .shuffle_start(b_st[1]), .shuffle_finish(b_fn[1]),
    .decrypt_start(b_st[2]), .decrypt_finish(b_fn[2]),
    .check_start(b_st[3]), .check_finish(b_fn[3]), .check_valid(1'b0),
    .core_reset(b_cr), .secret_key(b_key), .keys_tried(b_tried),
    .busy(b_busy), .done(b_done), .found(b_found), .error(b_err)
  );

  // Stub sub-blocks: one-cycle finish pulse on the third cycle of a held start
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_fn <= '0;
      b_fn <= '0;
      for (int i = 0; i < 4; i++) begin
        a_cnt[i] <= 0;
        b_cnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!a_st[i] || a_fn[i]) begin
          a_fn[i]  <= 1'b0;
          a_cnt[i] <= 0;
        end else if (a_cnt[i] == 2) a_fn[i] <= a_en[i];
        else a_cnt[i] <= a_cnt[i] + 1;
        if (!b_st[i] || b_fn[i]) begin
          b_fn[i]  <= 1'b0;
          b_cnt[i] <= 0;
        end else if (b_cnt[i] == 2) b_fn[i] <= 1'b1;
        else b_cnt[i] <= b_cnt[i] + 1;
      end
    end
  end

  always @(posedge clk) if (a_cr) a_crc <= a_crc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) b_nseen <= 0;
    else if (b_st[3] && b_fn[3] && b_nseen < 4) begin
      b_seen[b_nseen] <= b_key;
      b_nseen         <= b_nseen + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_a_done(input string tag);
    int n = 0;
    while (a_done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(a_done), 64'd1);
  endtask

  task automatic pulse_a_go();
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
  endtask

  initial begin
    int n;
    int crc0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_found", 64'(a_found), 64'd0);
    chk("rst_error", 64'(a_err), 64'd0);
    chk("rst_key", 64'(a_key), 64'd0);
    chk("rst_tried", 64'(a_tried), 64'd0);
    chk("rst_starts", 64'({a_st, a_cr}), 64'd0);
    chk("rst_b_key", 64'(b_key), 64'd2);

    // Test 1: valid on key 5
    a_target   = 8'd5;
    a_valid_en = 1'b1;
    pulse_a_go();
    chk("t1_load_core_reset", 64'(a_cr), 64'd1);
    chk("t1_load_busy", 64'(a_busy), 64'd1);
    @(negedge clk);
    chk("t1_init_start", 64'(a_st[0]), 64'd1);
    chk("t1_init_cr_low", 64'(a_cr), 64'd0);
    n = 0;
    while (!a_fn[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_init_finish_seen", 64'(a_fn[0]), 64'd1);
    chk("t1_start_held_on_finish", 64'(a_st[0]), 64'd1);
    @(negedge clk);
    chk("t1_init_start_drop", 64'(a_st[0]), 64'd0);
    chk("t1_shuffle_start", 64'(a_st[1]), 64'd1);
    wait_a_done("t1");
    chk("t1_found", 64'(a_found), 64'd1);
    chk("t1_key", 64'(a_key), 64'd5);
    chk("t1_tried", 64'(a_tried), 64'd6);
    chk("t1_busy", 64'(a_busy), 64'd0);
    chk("t1_check_start_low", 64'(a_st[3]), 64'd0);

    // Test 2: never valid, full range
    a_valid_en = 1'b0;
    crc0 = a_crc;
    pulse_a_go();
    chk("t2_found_cleared", 64'(a_found), 64'd0);
    chk("t2_tried_cleared", 64'(a_tried), 64'd0);
    wait_a_done("t2");
    chk("t2_found", 64'(a_found), 64'd0);
    chk("t2_key", 64'(a_key), 64'd7);
    chk("t2_tried", 64'(a_tried), 64'd8);
    chk("t2_core_resets", 64'(a_crc - crc0), 64'd8);

    // Test 3: strided instance visits 2, 6, 10
    b_go = 1'b1;
    @(negedge clk);
    b_go = 1'b0;
    n = 0;
    while (b_done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("t3_done", 64'(b_done), 64'd1);
    chk("t3_tried", 64'(b_tried), 64'd3);
    chk("t3_key", 64'(b_key), 64'd10);
    chk("t3_found", 64'(b_found), 64'd0);
    chk("t3_nseen", 64'(b_nseen), 64'd3);
    chk("t3_seen0", 64'(b_seen[0]), 64'd2);
    chk("t3_seen1", 64'(b_seen[1]), 64'd6);
    chk("t3_seen2", 64'(b_seen[2]), 64'd10);

    // Test 4: sibling stop during SHUFFLE of key 1, then same with key 1 valid
    for (int r = 0; r < 2; r++) begin
      a_target   = 8'd1;
      a_valid_en = (r == 1);
      pulse_a_go();
      n = 0;
      while (!(a_st[1] && a_key == 8'd1) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t4_in_shuffle_k1", 64'(a_st[1]), 64'd1);
      a_stop = 1'b1;
      @(negedge clk);
      a_stop = 1'b0;
      chk("t4_no_abort_mid_phase", 64'(a_busy), 64'd1);
      wait_a_done("t4");
      chk("t4_found", 64'(a_found), 64'(r));
      chk("t4_key", 64'(a_key), 64'd1);
      chk("t4_tried", 64'(a_tried), 64'd2);
    end

    // Test 5: decrypt never finishes, watchdog fires after 10 cycles
    a_valid_en = 1'b0;
    a_en[2]    = 1'b0;
    pulse_a_go();
    n = 0;
    while (!a_st[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (a_st[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_cycles_in_decrypt", 64'(n), 64'd10);
    chk("t5_done", 64'(a_done), 64'd1);
    chk("t5_error", 64'(a_err), 64'd1);
    chk("t5_found", 64'(a_found), 64'd0);
    chk("t5_decrypt_start", 64'(a_st[2]), 64'd0);
    chk("t5_tried", 64'(a_tried), 64'd0);
    a_en[2] = 1'b1;

    // Test 6: async reset in CHECK of key 3, then restart
    pulse_a_go();
    chk("t6_error_cleared", 64'(a_err), 64'd0);
    n = 0;
    while (!(a_st[3] && a_key == 8'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_check_k3", 64'(a_st[3]), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_check_start", 64'(a_st[3]), 64'd0);
    chk("t6_rst_busy", 64'(a_busy), 64'd0);
    chk("t6_rst_key", 64'(a_key), 64'd0);
    chk("t6_rst_tried", 64'(a_tried), 64'd0);
    chk("t6_rst_done", 64'(a_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_target   = 8'd2;
    a_valid_en = 1'b1;
    pulse_a_go();
    chk("t6_restart_key", 64'(a_key), 64'd0);
    chk("t6_restart_tried", 64'(a_tried), 64'd0);
    wait_a_done("t6");
    chk("t6_found", 64'(a_found), 64'd1);
    chk("t6_key", 64'(a_key), 64'd2);
    chk("t6_tried", 64'(a_tried), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
